// File: rtl/data_mem_io_responder_pkg.sv
// Shared definitions for the data-memory / IO responder slice.
// Address map constants, debouncer state encoding and decode bundle.
package data_mem_io_responder_pkg;

    localparam int IO_BASE_BIT = 31;

    localparam logic [3:0] IO_LED_OFF  = 4'h0;
    localparam logic [3:0] IO_SW_OFF   = 4'h4;
    localparam logic [3:0] IO_STAT_OFF = 4'h8;

    localparam logic DB_STABLE   = 1'b0;
    localparam logic DB_SETTLING = 1'b1;

    localparam logic LED_OFF_BIT = 1'b0;

    typedef struct packed {
        logic is_io;
        logic misalign;
        logic out_of_range;
        logic ram_hit;
        logic io_rd;
        logic io_wr;
    } decode_t;

endpackage

// File: rtl/data_mem_io_responder_switch_debouncer.sv
// Two-flop synchroniser plus counting debouncer for the board switches.
// A new value is accepted after it has differed from the stable one long enough.
module switch_debouncer
    import data_mem_io_responder_pkg::*;
#(
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] switch_in,
    output logic [SW_W-1:0] stable_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SW_W-1:0] sync1;
    logic [SW_W-1:0] sync2;
    logic [SW_W-1:0] stable;
    logic [CW-1:0]   cnt;
    logic            state;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            cnt    <= '0;
            state  <= DB_STABLE;
        end else begin
            sync1 <= switch_in;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt   <= '0;
                state <= DB_STABLE;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                state  <= DB_STABLE;
            end else begin
                // Counting is not restarted by a different non-stable value.
                cnt   <= (state == DB_STABLE) ? CNT_ONE : cnt + CNT_ONE;
                state <= DB_SETTLING;
            end
        end
    end

    assign stable_o = stable;

endmodule

// File: rtl/data_mem_io_responder.sv
// MEM-stage data responder: word RAM plus a small IO space at addr[31].
// Load data is combinational; stores, LED and error state update on the edge.
module data_mem_io_responder
    import data_mem_io_responder_pkg::*;
#(
    parameter int MEM_AW          = 10,
    parameter int SW_W            = 16,
    parameter int LED_W           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_i,
    input  logic             we_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    input  logic [SW_W-1:0]  switch_in,
    output logic [LED_W-1:0] led_out,
    output logic             err_o
);

    localparam int DEPTH = 1 << MEM_AW;

    logic [31:0]       mem [DEPTH];
    logic [SW_W-1:0]   sw_stable;
    logic [LED_W-1:0]  led_q;
    logic              err_q;
    decode_t           dec;
    logic [3:0]        io_off;
    logic [MEM_AW-1:0] widx;
    logic              acc_err;
    logic              io_wr_ok;
    logic              ram_we;
    logic              led_we;
    logic              stat_clr;
    logic [31:0]       io_rdata;

    switch_debouncer #(
        .SW_W           (SW_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk      (clk),
        .rst      (rst),
        .switch_in(switch_in),
        .stable_o (sw_stable)
    );

    assign io_off = addr_i[3:0];
    assign widx   = addr_i[MEM_AW+1:2];

    // IO stores arrive with ce_i low, so IO writes qualify on we_i alone.
    always_comb begin
        dec              = '0;
        dec.is_io        = addr_i[IO_BASE_BIT];
        dec.misalign     = addr_i[1:0] != 2'b00;
        dec.out_of_range = addr_i[30:MEM_AW+2] != '0;
        dec.ram_hit      = !dec.is_io && ce_i;
        dec.io_rd        = dec.is_io && ce_i;
        dec.io_wr        = dec.is_io && we_i;
    end

    assign acc_err  = (dec.ram_hit && (dec.misalign || dec.out_of_range))
                   || ((dec.io_rd || dec.io_wr) && dec.misalign);
    assign io_wr_ok = dec.io_wr && !acc_err;
    assign ram_we   = dec.ram_hit && we_i && !acc_err && !rst;
    assign led_we   = io_wr_ok && (io_off == IO_LED_OFF);
    assign stat_clr = io_wr_ok && (io_off == IO_STAT_OFF) && data_i[0];

    always_comb begin
        io_rdata = '0;
        case (io_off)
            IO_LED_OFF:  io_rdata = 32'(led_q);
            IO_SW_OFF:   io_rdata = 32'(sw_stable);
            IO_STAT_OFF: io_rdata = {31'd0, err_q};
            default:     io_rdata = '0;
        endcase
    end

    always_comb begin
        data_o = '0;
        if (rst || !ce_i || acc_err) begin
            data_o = '0;
        end else if (dec.is_io) begin
            data_o = io_rdata;
        end else begin
            data_o = mem[widx];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[widx] <= data_i;
        end
    end

    // A new error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= {LED_W{LED_OFF_BIT}};
            err_q <= 1'b0;
        end else begin
            if (led_we) begin
                led_q <= data_i[LED_W-1:0];
            end
            if (acc_err) begin
                err_q <= 1'b1;
            end else if (stat_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign led_out = led_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_data_mem_io_responder.sv
// Randomised and directed bench for data_mem_io_responder.
// Compares against a behavioural address-map / debounce model.
module tb_data_mem_io_responder;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_io_responder #(
        .MEM_AW         (10),
        .SW_W           (16),
        .LED_W          (16),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce_i     (ce_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .switch_in(switch_in),
        .led_out  (led_out),
        .err_o    (err_o)
    );

    logic [31:0] ram_m [int];
    logic [15:0] led_m;
    logic [15:0] sw_s1;
    logic [15:0] sw_s2;
    logic [15:0] sw_st;
    int          sw_run;
    bit          err_m;
    logic [31:0] rd_seen;
    logic [15:0] sw_r;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_bad();
        if (!addr_i[31])
            return ce_i && (addr_i[1:0] != 2'b00 || addr_i[30:12] != 19'd0);
        return (ce_i || we_i) && addr_i[1:0] != 2'b00;
    endfunction

    function automatic bit m_read(output logic [31:0] v);
        int idx;
        v = 32'h0;
        if (rst || !ce_i || m_bad()) return 1'b1;
        if (addr_i[31]) begin
            case (addr_i[3:0])
                4'h0:    v = {16'h0, led_m};
                4'h4:    v = {16'h0, sw_st};
                4'h8:    v = {31'h0, err_m};
                default: v = 32'h0;
            endcase
            return 1'b1;
        end
        idx = int'(addr_i[11:2]);
        if (!ram_m.exists(idx)) return 1'b0;
        v = ram_m[idx];
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit bad;
        bad = m_bad();
        if (rst) begin
            led_m = 16'h0;
            err_m = 1'b0;
            sw_s1 = 16'h0;
            sw_s2 = 16'h0;
            sw_st = 16'h0;
            sw_run = 0;
            return;
        end
        if (!addr_i[31] && ce_i && we_i && !bad)
            ram_m[int'(addr_i[11:2])] = data_i;
        if (addr_i[31] && we_i && !bad) begin
            if (addr_i[3:0] == 4'h0) led_m = data_i[15:0];
            if (addr_i[3:0] == 4'h8 && data_i[0]) err_m = 1'b0;
        end
        if (bad) err_m = 1'b1;
        // accept once the synchronised input has differed for DB edges in a row
        if (sw_s2 == sw_st) begin
            sw_run = 0;
        end else begin
            sw_run++;
            if (sw_run == DB) begin
                sw_st = sw_s2;
                sw_run = 0;
            end
        end
        sw_s2 = sw_s1;
        sw_s1 = switch_in;
    endtask

    task automatic step(input bit r, input bit c, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [15:0] s);
        logic [31:0] ev;
        bit known;
        rst = r;
        ce_i = c;
        we_i = w;
        addr_i = a;
        data_i = d;
        switch_in = s;
        #2;
        rd_seen = data_o;
        known = m_read(ev);
        if (known) check("data_o", data_o, ev);
        @(posedge clk);
        model_edge();
        #1;
        check("led_out", {16'h0, led_out}, {16'h0, led_m});
        check("err_o", {31'h0, err_o}, {31'h0, err_m});
    endtask

    initial begin
        step(1, 0, 0, 32'h0, 32'h0, 16'hFFFF);
        step(1, 0, 0, 32'h0, 32'h0, 16'hFFFF);
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        step(0, 0, 0, 32'h8000_0004, 32'h0, 16'h0);
        check("rst_ce0", rd_seen, 32'h0);
        step(0, 1, 0, 32'h8000_0004, 32'h0, 16'h0);
        check("rst_sw_rd", rd_seen, 32'h0);

        step(0, 1, 1, 32'h10, 32'h1234_5678, 16'h0);
        step(0, 1, 0, 32'h10, 32'h0, 16'h0);
        check("ram_rt", rd_seen, 32'h1234_5678);
        step(0, 1, 1, 32'h10, 32'h0BAD_F00D, 16'h0);
        check("ram_rdw_old", rd_seen, 32'h1234_5678);
        step(0, 1, 0, 32'h10, 32'h0, 16'h0);
        check("ram_new", rd_seen, 32'h0BAD_F00D);

        step(0, 0, 1, 32'h8000_0000, 32'hABCD_5A5A, 16'h0);
        check("led_wr", {16'h0, led_out}, 32'h5A5A);
        step(0, 1, 0, 32'h8000_0000, 32'h0, 16'h0);
        check("led_rd", rd_seen, 32'h5A5A);

        for (int i = 0; i <= 6; i++) begin
            step(0, 1, 0, 32'h8000_0004, 32'h0, 16'h00F0);
            check("db_step", rd_seen, (i == 6) ? 32'hF0 : 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 32'h8000_0004, 32'h0, (i < 2) ? 16'h0003 : 16'h00F0);
            check("db_glitch", rd_seen, 32'hF0);
        end

        step(0, 1, 1, 32'h4, 32'h1111_2222, 16'h00F0);
        step(0, 1, 1, 32'h6, 32'hDEAD_BEEF, 16'h00F0);
        check("err_set", {31'h0, err_o}, 32'h1);
        step(0, 1, 0, 32'h4, 32'h0, 16'h00F0);
        check("err_nowr", rd_seen, 32'h1111_2222);
        step(0, 1, 1, 32'h0010_0000, 32'h5, 16'h00F0);
        check("err_oor", {31'h0, err_o}, 32'h1);
        step(0, 0, 1, 32'h8000_0008, 32'h1, 16'h00F0);
        check("err_clr", {31'h0, err_o}, 32'h0);
        step(0, 1, 0, 32'h8000_0008, 32'h0, 16'h00F0);
        check("stat_rd", rd_seen, 32'h0);

        for (int i = 0; i < 4; i++)
            step(i == 3, 1, 0, 32'h8000_0004, 32'h0, 16'h0F00);
        check("rst_mid_led", {16'h0, led_out}, 32'h0);
        for (int j = 1; j <= 7; j++) begin
            step(0, 1, 0, 32'h8000_0004, 32'h0, 16'h0F00);
            check("db_rst", rd_seen, (j == 7) ? 32'h0F00 : 32'h0);
        end

        sw_r = 16'h0F00;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = 32'($urandom_range(0, 7)) << 2;
                5:             a = 32'($urandom_range(0, 31));
                6:             a = 32'h0000_1000 | (32'($urandom_range(0, 7)) << 2);
                7, 8:          a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2);
                default:       a = 32'h8000_0000 | 32'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0:       sw_r = 16'h0000;
                    1:       sw_r = 16'h00F0;
                    2:       sw_r = 16'h0F00;
                    3:       sw_r = 16'hFFFF;
                    default: sw_r = 16'($urandom);
                endcase
            end
            step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, a, $urandom, sw_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
